instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_if.sv | 38 +++
 rtl/instr_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// Signal bundle between the instruction sequencer and its memories, ALU and register file.
// Handshake: a request (imem_req/dmem_req) is held high until the matching ack is seen at a rising edge; acks outside a request are ignored.
interface instr_sequencer_if #(
   parameter int PC_W = 8
);
   logic            run;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_data;
   logic [3:0]      alu_op;
   logic            alu_s;
   logic [3:0]      alu_cond;
   logic [15:0]     alu_imm;
   logic [3:0]      rf_rs1;
   logic [3:0]      rf_rs2;
   logic [3:0]      rf_rd;
   logic            rf_we;
   logic [3:0]      alu_flags;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;
   logic [3:0]      flags;
   logic [PC_W-1:0] pc;
   logic [2:0]      state;

   modport master (
      input  run, imem_ack, imem_data, alu_flags, dmem_ack,
      output imem_req, imem_addr, alu_op, alu_s, alu_cond, alu_imm,
             rf_rs1, rf_rs2, rf_rd, rf_we, dmem_req, dmem_we, flags, pc, state
   );

   modport slave (
      output run, imem_ack, imem_data, alu_flags, dmem_ack,
      input  imem_req, imem_addr, alu_op, alu_s, alu_cond, alu_imm,
             rf_rs1, rf_rs2, rf_rd, rf_we, dmem_req, dmem_we, flags, pc, state
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, conditional execute, data memory access
// and register write-back, with an architectural NZCV flag register.
module instr_sequencer #(
   parameter int PC_W = 8
) (
   input logic               clk,
   input logic               reset,
   instr_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [3:0] OP_CMP = 4'b1011;
   localparam logic [3:0] OP_LDR = 4'b1101;
   localparam logic [3:0] OP_STR = 4'b1110;
   localparam logic [3:0] OP_NOP = 4'b1111;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q;
   logic [3:0]      flags_q;
   logic [31:0]     ir_q;
   logic            cond_pass_q;

   logic pc_inc, ir_load, cond_load, flags_load, boundary;
   logic imem_req, dmem_req, dmem_we, rf_we;

   // Instruction fields; the alu/rf outputs come straight from IR so they hold
   // steady from DECODE until the next fetch completes.
   logic [3:0]  ir_cond, ir_op, ir_rd, ir_rs1, ir_rs2;
   logic        ir_s;
   logic [15:0] ir_imm;

   assign ir_cond = ir_q[31:28];
   assign ir_op   = ir_q[27:24];
   assign ir_s    = ir_q[23];
   assign ir_rd   = ir_q[22:19];
   assign ir_rs1  = ir_q[18:15];
   assign ir_rs2  = ir_q[14:11];
   assign ir_imm  = ir_q[15:0];

   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cond)
         4'd0:    cond_ok = 1'b1;
         4'd1:    cond_ok = z;
         4'd2:    cond_ok = !z;
         4'd3:    cond_ok = c;
         4'd4:    cond_ok = !c;
         4'd5:    cond_ok = n;
         4'd6:    cond_ok = !n;
         4'd7:    cond_ok = v;
         4'd8:    cond_ok = !v;
         4'd9:    cond_ok = c && !z;
         4'd10:   cond_ok = !c || z;
         4'd11:   cond_ok = (n == v);
         4'd12:   cond_ok = (n != v);
         4'd13:   cond_ok = !z && (n == v);
         4'd14:   cond_ok = z || (n != v);
         default: cond_ok = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      ir_load    = 1'b0;
      cond_load  = 1'b0;
      flags_load = 1'b0;
      boundary   = 1'b0;
      pc_inc     = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.run) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ack) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            cond_load = 1'b1;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            if (!cond_pass_q) begin
               boundary = 1'b1;
            end else begin
               flags_load = ir_s || (ir_op == OP_CMP);
               if (ir_op == OP_LDR || ir_op == OP_STR) state_d = S_MEM;
               else if (ir_op == OP_CMP || ir_op == OP_NOP) boundary = 1'b1;
               else state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (ir_op == OP_STR);
            if (bus.dmem_ack) begin
               if (ir_op == OP_LDR) state_d = S_WB;
               else boundary = 1'b1;
            end
         end
         S_WB: begin
            rf_we    = 1'b1;
            boundary = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // Instruction boundary: advance pc and either keep sequencing or park in IDLE.
      if (boundary) begin
         pc_inc  = 1'b1;
         state_d = bus.run ? S_FETCH : S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         flags_q     <= '0;
         ir_q        <= '0;
         cond_pass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pc_inc)     pc_q        <= pc_q + PC_W'(1);
         if (ir_load)    ir_q        <= bus.imem_data;
         if (cond_load)  cond_pass_q <= cond_ok(ir_cond, flags_q);
         if (flags_load) flags_q     <= bus.alu_flags;
      end
   end

   assign bus.imem_req  = imem_req;
   assign bus.imem_addr = pc_q;
   assign bus.alu_op    = ir_op;
   assign bus.alu_s     = ir_s;
   assign bus.alu_cond  = ir_cond;
   assign bus.alu_imm   = ir_imm;
   assign bus.rf_rs1    = ir_rs1;
   assign bus.rf_rs2    = ir_rs2;
   assign bus.rf_rd     = ir_rd;
   assign bus.rf_we     = rf_we;
   assign bus.dmem_req  = dmem_req;
   assign bus.dmem_we   = dmem_we;
   assign bus.flags     = flags_q;
   assign bus.pc        = pc_q;
   assign bus.state     = state_q;

endmodule
